ahb_slave_responder: RTL

// AHB-Lite slave (responder) with internal word memory, placed on each slave port of the

---
 rtl/ahb_slave_responder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ahb_slave_responder.sv
// AHB-Lite slave with an internal word memory, programmable wait states and byte-lane writes.
// Define AHB_SLAVE_ERR_RESP_EN to enable the two-cycle ERROR response for bad accesses.
module ahb_slave_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int SLAVE_ADDR_BITS = 12,
  parameter int MEM_DEPTH       = 1024
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hselx,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hmastlock,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic [3:0]            wait_cfg,
  output logic                  hreadyout,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic [1:0]            hresp
);

  localparam int IDX_W  = SLAVE_ADDR_BITS - 2;
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_LIM = MEM_DEPTH[IDX_W:0];
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;

  logic              wr_p1;
  logic              bad_p1;
  logic [MEM_AW-1:0] idx_p1;
  logic [3:0]        lanes_p1;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IDX_W-1:0] a_idx;
  logic [3:0]       a_lanes;
  logic             a_in_range;
  logic             a_size_ok;
  logic             a_align_ok;
  logic             a_bad;
  logic             can_take;
  logic             take;
  logic             commit;

  // Upper address bits are decoded by the interconnect; burst/protection info is not used.
  logic unused_inputs;
  assign unused_inputs = ^{haddr[ADDR_WIDTH-1:SLAVE_ADDR_BITS], hburst, hprot, hmastlock, htrans[0]};

  // Address phase: legality and byte-lane decode
  always_comb begin
    a_idx      = haddr[SLAVE_ADDR_BITS-1:2];
    a_in_range = ({1'b0, a_idx} < DEPTH_LIM);
    a_lanes    = 4'b0000;
    a_size_ok  = 1'b1;
    a_align_ok = 1'b1;
    case (hsize)
      3'b000: a_lanes = 4'b0001 << haddr[1:0];
      3'b001: begin
        a_lanes    = haddr[1] ? 4'b1100 : 4'b0011;
        a_align_ok = ~haddr[0];
      end
      3'b010: begin
        a_lanes    = 4'b1111;
        a_align_ok = (haddr[1:0] == 2'b00);
      end
      default: a_size_ok = 1'b0;
    endcase
    a_bad = ~(a_in_range & a_size_ok & a_align_ok);
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    hreadyout = 1'b1;
    hresp     = RESP_OKAY;
    can_take  = 1'b0;
    case (state_q)
      S_IDLE: can_take = 1'b1;
      S_DATA: begin
        hreadyout = (wcnt_q == '0);
        can_take  = (wcnt_q == '0);
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = RESP_ERROR;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        hresp    = RESP_ERROR;
        can_take = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new address phase completes on the same edge as the previous data phase
    take = hselx & hready & htrans[1] & can_take;
    if (take) begin
      state_d = S_DATA;
      wcnt_d  = wait_cfg;
    end
`ifdef AHB_SLAVE_ERR_RESP_EN
    if (take && a_bad) begin
      state_d = S_ERR1;
      wcnt_d  = '0;
    end
`else
    hresp = RESP_OKAY;
`endif
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      wr_p1   <= 1'b0;
      bad_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (take) begin
        wr_p1  <= hwrite;
        bad_p1 <= a_bad;
      end
    end
  end

  // Address-phase to data-phase boundary
  always_ff @(posedge hclk) begin
    if (take) begin
      idx_p1   <= a_idx[MEM_AW-1:0];
      lanes_p1 <= a_lanes;
    end
  end

  assign commit = (state_q == S_DATA) & (wcnt_q == '0) & wr_p1 & ~bad_p1;

  always_ff @(posedge hclk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes_p1[b]) mem[idx_p1][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  // Reads present the stored word for the whole data phase; dropped accesses read as zero.
  assign hrdata = ((state_q == S_DATA) && !wr_p1 && !bad_p1) ? mem[idx_p1] : '0;

endmodule
